// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier for MULT/MULTU; one CLA add-with-carry per CALC cycle, HI/LO result registers.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+34; one operation per 35 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE (busy=0) and ignored while busy.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int NG = WIDTH / 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   acc;
  logic               sign_q;
  logic               neg;
  logic               accept;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_g;
  logic [WIDTH-1:0]   add_p;
  logic [WIDTH-1:0]   add_c;
  logic [NG:0]        grp_c;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;

  assign busy   = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done   = (state == S_DONE);
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Two's-complement negate leaves 0x80000000 unchanged, which is its unsigned magnitude.
  assign a_mag = (sign_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
  assign b_mag = (sign_q && m[WIDTH-1])   ? (~m + WIDTH'(1))   : m;

  assign add_b = m[0] ? a_q : '0;

  // Carry-lookahead add: 4-bit lookahead groups, group carries chained.
  always_comb begin
    add_g    = acc & add_b;
    add_p    = acc ^ add_b;
    add_c    = '0;
    grp_c    = '0;
    grp_c[0] = 1'b0;
    for (int gi = 0; gi < NG; gi++) begin
      add_c[4*gi]   = grp_c[gi];
      add_c[4*gi+1] = add_g[4*gi] | (add_p[4*gi] & grp_c[gi]);
      add_c[4*gi+2] = add_g[4*gi+1]
                    | (add_p[4*gi+1] & add_g[4*gi])
                    | (add_p[4*gi+1] & add_p[4*gi] & grp_c[gi]);
      add_c[4*gi+3] = add_g[4*gi+2]
                    | (add_p[4*gi+2] & add_g[4*gi+1])
                    | (add_p[4*gi+2] & add_p[4*gi+1] & add_g[4*gi])
                    | (add_p[4*gi+2] & add_p[4*gi+1] & add_p[4*gi] & grp_c[gi]);
      grp_c[gi+1]   = add_g[4*gi+3]
                    | (add_p[4*gi+3] & add_g[4*gi+2])
                    | (add_p[4*gi+3] & add_p[4*gi+2] & add_g[4*gi+1])
                    | (add_p[4*gi+3] & add_p[4*gi+2] & add_p[4*gi+1] & add_g[4*gi])
                    | (add_p[4*gi+3] & add_p[4*gi+2] & add_p[4*gi+1] & add_p[4*gi] & grp_c[gi]);
    end
  end

  assign sum  = add_p ^ add_c;
  assign cout = grp_c[NG];

  assign prod_mag = {acc, m};
  assign prod     = neg ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      m      <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q    <= a;
            m      <= b;
            sign_q <= sign;
            state  <= S_PREP;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_PREP: begin
          a_q   <= a_mag;
          m     <= b_mag;
          neg   <= sign_q & (a_q[WIDTH-1] ^ m[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
          state <= S_CALC;
        end
        S_CALC: begin
          // The carry-out becomes the new MSB so no product bit is lost.
          acc <= {cout, sum[WIDTH-1:1]};
          m   <= {sum[0], m[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt   <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          hi    <= prod[2*WIDTH-1:WIDTH];
          lo    <= prod[WIDTH-1:0];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n) state <= S_DONE);

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle multiplier for the MIPS datapath. Executes MULT and MULTU and writes the HI/LO pair.
- Sits downstream of the 32-bit carry-lookahead adder. It uses one 32-bit add-with-carry-out per cycle as its accumulation step and consumes the sum and carry-out each iteration.
- Radix-2 shift-add on operand magnitudes, followed by a conditional 64-bit two's-complement fix-up for signed operation.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; only 32 is supported and verified.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
sign  input  1  1 = MULT (signed), 0 = MULTU (unsigned); sampled with start
a  input  32  multiplicand; sampled with start
b  input  32  multiplier; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo valid and newly updated
hi  output  32  product bits [63:32]
lo  output  32  product bits [31:0]

Behaviour:
- Reset: rst_n low forces state IDLE asynchronously.
  - Outputs: busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is ever visible.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: start=1 at edge E0 latches a, b and sign, then goes to PREP.
- PREP (1 cycle):
  - Signed: magnitudes |a| and |b|. 0x80000000 maps to magnitude 0x80000000, treated as unsigned.
  - neg flag = sign & (a[31]^b[31]).
  - Unsigned: operands pass through and neg=0.
  - Clear accumulator acc[31:0]=0, multiplier register m=|b|, cnt=0, then go to CALC.
- CALC (exactly 32 cycles, cnt 0..31):
  - If m[0]=1: {c,s} = acc + |a| (32-bit add with carry-out); otherwise {c,s} = {0,acc}.
  - Then shift right {c,s,m} by one: acc <= {c,s[31:1]}, m <= {s[0],m[31:1]}.
  - After cnt=31 go to FIX. The 64-bit product magnitude is {acc,m}.
- FIX (1 cycle): if neg, product = ~{acc,m} + 1 (64-bit, carry across the halves); otherwise unchanged. Go to DONE.
- DONE (1 cycle):
  - hi/lo register the product on entry, so they are visible during DONE.
  - done=1 for this cycle only.
  - Next state is IDLE. If start=1 in DONE, it is accepted exactly as in IDLE and goes to PREP.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0+34. Throughput is one operation per 35 cycles (back-to-back via DONE).
- busy is 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
- start while busy=1 is ignored and has no effect on the in-flight operation or its operands. Input changes while busy are ignored.
- hi/lo hold their last result until the next DONE; they never change during PREP/CALC/FIX.
- Width rules:
  - Accumulator carry-out must be retained (a 33-bit intermediate). No truncation of the 64-bit product.
  - Unsigned max: 0xFFFFFFFF*0xFFFFFFFF must not overflow.
- No X propagation: all state registers are reset; the counter wraps only under state control, never free-running.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly 1 cycle, 34 edges after the start edge; busy high for 34 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0, lo=1.
- MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0. MULT a=0x80000000 b=1 -> hi=0xFFFFFFFF, lo=0x80000000. MULTU a=0 b=0x12345678 -> hi=0, lo=0.
- Issue MULTU 7*6, then pulse start with a=9, b=9 at cycle 10 while busy -> result hi=0, lo=42; exactly one done pulse; no second operation starts.
- Hold start=1 continuously with new operands presented in the DONE cycle (MULTU 3*4 then 5*5) -> first done gives lo=12; second operation begins from DONE; second done gives lo=25, 35 cycles later.
- Assert rst_n=0 asynchronously mid-CALC (cnt=15) -> busy, done, hi and lo go to 0 immediately without a clock edge. After release, MULTU 2*3 -> lo=6 with nominal latency.
